// File: rtl/pattern_scheduler_if.sv
// Host command / status bundle for pattern_scheduler.
// The host drives the master modport and the scheduler implements the slave modport.
interface pattern_scheduler_if #(
  parameter int MODE_W = 2,
  parameter int HOLD_W = 8,
  parameter int DEPTH  = 4
);
  logic                     CMD_VALID;
  logic                     CMD_READY;
  logic [MODE_W-1:0]        CMD_MODE;
  logic [HOLD_W-1:0]        CMD_HOLD;
  logic                     FLUSH;
  logic [MODE_W-1:0]        PAT_MODE;
  logic                     FRAME_TICK;
  logic                     EXHAUSTED;
  logic                     BUSY;
  logic [$clog2(DEPTH):0]   LEVEL;

  modport master (
    output CMD_VALID, CMD_MODE, CMD_HOLD, FLUSH,
    input  CMD_READY, PAT_MODE, FRAME_TICK, EXHAUSTED, BUSY, LEVEL
  );

  modport slave (
    input  CMD_VALID, CMD_MODE, CMD_HOLD, FLUSH,
    output CMD_READY, PAT_MODE, FRAME_TICK, EXHAUSTED, BUSY, LEVEL
  );
endinterface

// File: rtl/pattern_scheduler.sv
// Frame-synchronous test-pattern sequencer: queued {mode, hold} commands are applied on VGA_VS falling edges.
// Optional PATTERN_SCHED_AUTOCYCLE_EN: steps PAT_MODE every AUTO_FRAMES frames while lingering.
module pattern_scheduler #(
  parameter int MODE_W      = 2,
  parameter int HOLD_W      = 8,
  parameter int DEPTH       = 4,
  parameter int AUTO_FRAMES = 60
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 VGA_VS,
  pattern_scheduler_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHOW   = 2'd1;
  localparam logic [1:0] LINGER = 2'd2;

  logic [1:0]        state;
  logic              vs_q;
  logic [HOLD_W-1:0] remain;
  logic [MODE_W-1:0] pat_mode;
  logic              frame_tick;
  logic              exhausted;

  logic [MODE_W-1:0] mode_mem [DEPTH];
  logic [HOLD_W-1:0] hold_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  count;

  logic full;
  logic empty;
  logic fs;
  logic push;
  logic load;

  // Readiness comes from the registered count, so a pop in a full cycle never admits a same-cycle push.
  assign full  = (count == LVL_W'(DEPTH));
  assign empty = (count == '0);
  assign fs    = vs_q & ~VGA_VS;
  assign push  = bus.CMD_VALID && bus.CMD_READY;
  assign load  = fs && !empty && !bus.FLUSH && ((state != SHOW) || (remain == '0));

  assign bus.CMD_READY  = !full && !bus.FLUSH;
  assign bus.PAT_MODE   = pat_mode;
  assign bus.FRAME_TICK = frame_tick;
  assign bus.EXHAUSTED  = exhausted;
  assign bus.BUSY       = (state != IDLE);
  assign bus.LEVEL      = count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      vs_q       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      vs_q       <= VGA_VS;
      frame_tick <= fs;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || bus.FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (load) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + LVL_W'(push) - LVL_W'(load);
    end
  end

  // NOTE: the command storage has no reset; an entry is only read after it has been written, and leaving it out keeps it in plain RAM.
  always_ff @(posedge CLK) begin
    if (push) begin
      mode_mem[wr_ptr] <= bus.CMD_MODE;
      hold_mem[wr_ptr] <= bus.CMD_HOLD;
    end
  end

`ifdef PATTERN_SCHED_AUTOCYCLE_EN
  localparam int AUTO_W = $clog2(AUTO_FRAMES + 1);
  logic [AUTO_W-1:0] auto_cnt;
`else
  logic unused_auto_cfg;
  assign unused_auto_cfg = ^AUTO_FRAMES;
`endif

  always_ff @(posedge CLK) begin
    if (RST || bus.FLUSH) begin
      state     <= IDLE;
      pat_mode  <= '0;
      remain    <= '0;
      exhausted <= 1'b0;
`ifdef PATTERN_SCHED_AUTOCYCLE_EN
      auto_cnt  <= '0;
`endif
    end else begin
      exhausted <= 1'b0;
      if (load) begin
        state    <= SHOW;
        pat_mode <= mode_mem[rd_ptr];
        remain   <= hold_mem[rd_ptr];
      end else if (fs) begin
        case (state)
          SHOW: begin
            if (remain != '0) begin
              remain <= remain - HOLD_W'(1);
            end else begin
              state     <= LINGER;
              exhausted <= 1'b1;
`ifdef PATTERN_SCHED_AUTOCYCLE_EN
              auto_cnt  <= '0;
`endif
            end
          end
          LINGER: begin
`ifdef PATTERN_SCHED_AUTOCYCLE_EN
            if (auto_cnt == AUTO_W'(AUTO_FRAMES - 1)) begin
              pat_mode <= pat_mode + MODE_W'(1);
              auto_cnt <= '0;
            end else begin
              auto_cnt <= auto_cnt + AUTO_W'(1);
            end
`endif
          end
          IDLE:    ;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pattern_scheduler.sv
// Self-checking bench for pattern_scheduler: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_pattern_scheduler;
  localparam int MODE_W      = 2;
  localparam int HOLD_W      = 8;
  localparam int DEPTH       = 4;
  localparam int AUTO_FRAMES = 2;

  logic CLK = 1'b0;
  logic RST;
  logic VGA_VS;

  pattern_scheduler_if #(.MODE_W(MODE_W), .HOLD_W(HOLD_W), .DEPTH(DEPTH)) sched_bus ();

  pattern_scheduler #(
    .MODE_W(MODE_W), .HOLD_W(HOLD_W), .DEPTH(DEPTH), .AUTO_FRAMES(AUTO_FRAMES)
  ) dut (
    .CLK(CLK), .RST(RST), .VGA_VS(VGA_VS), .bus(sched_bus)
  );

  always #5 CLK = ~CLK;

  typedef struct { int mode; int hold; } cmd_t;

  // Reference model: a queue of pending commands plus "frames still to show" for the active one.
  cmd_t q[$];
  int   m_mode;
  int   m_frames_left;
  bit   m_active;
  bit   m_linger;
  bit   m_tick;
  bit   m_exh;
  bit   m_vs_prev;
  int   m_auto;

  int checks = 0;
  int errors = 0;
  int exh_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_mode = 0; m_frames_left = 0; m_active = 0; m_linger = 0;
    m_tick = 0; m_exh = 0; m_vs_prev = 1; m_auto = 0;
  endfunction

  // Advances the model by one clock using the inputs currently applied to the DUT.
  function automatic void model_step();
    bit   fs;
    bit   ready;
    cmd_t c;
    if (RST) begin
      model_reset();
      return;
    end
    fs        = m_vs_prev && !VGA_VS;
    ready     = (q.size() < DEPTH) && !sched_bus.FLUSH;
    m_vs_prev = VGA_VS;
    m_tick    = fs;
    m_exh     = 0;
    if (sched_bus.FLUSH) begin
      q.delete();
      m_mode = 0; m_frames_left = 0; m_active = 0; m_linger = 0; m_auto = 0;
      return;
    end
    if (fs) begin
      if ((!m_active || m_frames_left == 1) && q.size() > 0) begin
        c = q.pop_front();
        m_mode = c.mode; m_frames_left = c.hold + 1;
        m_active = 1; m_linger = 0;
      end else if (m_active && m_frames_left > 1) begin
        m_frames_left--;
      end else if (m_active) begin
        m_active = 0; m_linger = 1; m_exh = 1; m_auto = 0;
      end else if (m_linger) begin
`ifdef PATTERN_SCHED_AUTOCYCLE_EN
        m_auto++;
        if (m_auto == AUTO_FRAMES) begin
          m_mode = (m_mode + 1) % (1 << MODE_W);
          m_auto = 0;
        end
`endif
      end
    end
    if (sched_bus.CMD_VALID && ready) begin
      c.mode = int'(sched_bus.CMD_MODE);
      c.hold = int'(sched_bus.CMD_HOLD);
      q.push_back(c);
    end
  endfunction

  task automatic cyc();
    model_step();
    @(posedge CLK);
    #1;
    check("PAT_MODE",   sched_bus.PAT_MODE,   m_mode);
    check("FRAME_TICK", sched_bus.FRAME_TICK, m_tick);
    check("EXHAUSTED",  sched_bus.EXHAUSTED,  m_exh);
    check("BUSY",       sched_bus.BUSY,       m_active || m_linger);
    check("LEVEL",      sched_bus.LEVEL,      q.size());
    check("CMD_READY",  sched_bus.CMD_READY,  (q.size() < DEPTH) && !sched_bus.FLUSH);
    if (sched_bus.EXHAUSTED === 1'b1) exh_seen++;
  endtask

  task automatic frame();
    VGA_VS = 1'b0; cyc();
    VGA_VS = 1'b1; cyc(); cyc();
  endtask

  task automatic push(input int mode, input int hold);
    sched_bus.CMD_VALID = 1'b1;
    sched_bus.CMD_MODE  = MODE_W'(mode);
    sched_bus.CMD_HOLD  = HOLD_W'(hold);
    cyc();
    sched_bus.CMD_VALID = 1'b0;
  endtask

  task automatic flush_q();
    sched_bus.FLUSH = 1'b1; cyc();
    sched_bus.FLUSH = 1'b0;
  endtask

  initial begin
    int e;
    model_reset();
    RST = 1'b1; VGA_VS = 1'b1;
    sched_bus.CMD_VALID = 1'b0; sched_bus.CMD_MODE = '0;
    sched_bus.CMD_HOLD = '0; sched_bus.FLUSH = 1'b0;

    repeat (3) cyc();
    RST = 1'b0;
    check("rst_pat_mode", sched_bus.PAT_MODE, 0);
    check("rst_busy",     sched_bus.BUSY, 0);
    check("rst_level",    sched_bus.LEVEL, 0);
    check("rst_ready",    sched_bus.CMD_READY, 1);

    // Single command with one extra frame of hold, then exhaustion.
    push(2, 1);
    frame(); check("t2_fs1_mode", sched_bus.PAT_MODE, 2);
    frame(); check("t2_fs2_mode", sched_bus.PAT_MODE, 2);
    e = exh_seen;
    frame(); check("t2_fs3_mode", sched_bus.PAT_MODE, 2);
    check("t2_linger_busy", sched_bus.BUSY, 1);
    check("t2_exh_pulse",   exh_seen - e, 1);

    // Fill the queue, hold a 5th push until a frame start frees a slot.
    flush_q();
    for (int i = 0; i < 4; i++) push(i, 0);
    check("t3_full_level", sched_bus.LEVEL, 4);
    check("t3_full_ready", sched_bus.CMD_READY, 0);
    sched_bus.CMD_VALID = 1'b1; sched_bus.CMD_MODE = 2'd3; sched_bus.CMD_HOLD = '0;
    cyc();          check("t3_held_level", sched_bus.LEVEL, 4);
    VGA_VS = 1'b0; cyc(); check("t3_pop_level", sched_bus.LEVEL, 3);
    VGA_VS = 1'b1; cyc(); check("t3_push_level", sched_bus.LEVEL, 4);
    sched_bus.CMD_VALID = 1'b0;
    repeat (6) frame();

    // Back-to-back single-frame commands.
    flush_q();
    push(1, 0); push(2, 0); push(3, 0);
    frame(); check("t4_mode1", sched_bus.PAT_MODE, 1);
    frame(); check("t4_mode2", sched_bus.PAT_MODE, 2);
    frame(); check("t4_mode3", sched_bus.PAT_MODE, 3);
    e = exh_seen;
    frame(); check("t4_exh_pulse", exh_seen - e, 1);

    // FLUSH beats a concurrent push.
    flush_q();
    push(1, 5); push(2, 5); push(3, 5);
    frame(); check("t5_level_before", sched_bus.LEVEL, 2);
    sched_bus.FLUSH = 1'b1; sched_bus.CMD_VALID = 1'b1;
    cyc();
    sched_bus.FLUSH = 1'b0; sched_bus.CMD_VALID = 1'b0;
    check("t5_level", sched_bus.LEVEL, 0);
    check("t5_mode",  sched_bus.PAT_MODE, 0);
    check("t5_busy",  sched_bus.BUSY, 0);

`ifdef PATTERN_SCHED_AUTOCYCLE_EN
    flush_q();
    push(3, 0);
    frame(); frame();
    frame(); frame(); check("t6_auto_wrap", sched_bus.PAT_MODE, 0);
    frame(); frame(); check("t6_auto_step", sched_bus.PAT_MODE, 1);
`endif

    // Randomized traffic including rare flushes and mid-frame resets.
    for (int n = 0; n < 3000; n++) begin
      RST                 = ($urandom_range(0, 499) == 0);
      sched_bus.FLUSH     = ($urandom_range(0, 59) == 0);
      sched_bus.CMD_VALID = $urandom_range(0, 1);
      sched_bus.CMD_MODE  = MODE_W'($urandom);
      sched_bus.CMD_HOLD  = HOLD_W'($urandom_range(0, 3));
      VGA_VS              = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
